// File: rtl/seq_detect_prog.sv
// seq_detect_prog: programmable serial bit-pattern detector.
// A pattern of 1..WIDTH bits is compared against the most recent accepted
// bits. The match output is combinational (Mealy), match_q is its registered
// copy, and match_cnt counts matches, saturating at all-ones.
//
// Handshake: a bit on `in` is accepted at a rising edge only when
// in_valid=1 and cfg_we=0. in_valid has no ready counterpart; the detector
// always accepts. A cfg_we cycle wins over in_valid and discards that bit.
module seq_detect_prog #(
    parameter int               WIDTH           = 8,
    parameter logic [WIDTH-1:0] DEFAULT_PATTERN = 8'b0000_1001,
    parameter int               DEFAULT_LEN     = 4,
    parameter int               CNT_W           = 8,
    localparam int              LEN_W           = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [WIDTH-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    output logic             cfg_err,
    input  logic             in_valid,
    input  logic             in,
    output logic             match,
    output logic             match_q,
    output logic [CNT_W-1:0] match_cnt
);

    // fill counts 0..WIDTH-1, so it needs clog2(WIDTH) bits (WIDTH >= 2).
    localparam int               FILL_W   = $clog2(WIDTH);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    // Configuration registers.
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             overlap_q, overlap_d;

    // Stream state: previously accepted bits and how many of them are usable.
    logic [WIDTH-2:0]  hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;

    // Outputs that are registered.
    logic             match_q_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    // Candidate window, comparison mask and match qualifiers.
    logic [WIDTH-1:0] cand;
    logic [WIDTH-1:0] len_mask;
    logic             fill_ok;
    logic             pat_eq;
    logic             cfg_len_ok;

    // Build the candidate window and the mask selecting the low len bits.
    always_comb begin
        cand     = {hist_q, in};
        len_mask = '0;
        for (int i = 0; i < WIDTH; i++) begin
            len_mask[i] = (i < int'(len_q));
        end
    end

    // Mealy match: enough history, window equals pattern, bit accepted, not in reset.
    always_comb begin
        fill_ok = (LEN_W'(fill_q) >= (len_q - LEN_W'(1)));
        pat_eq  = ((cand & len_mask) == (pat_q & len_mask));
        match   = rst && in_valid && !cfg_we && fill_ok && pat_eq;
    end

    // Legal lengths are 1..WIDTH; anything else is rejected with cfg_err.
    always_comb begin
        cfg_len_ok = (cfg_len != '0) && (cfg_len <= LEN_W'(WIDTH));
    end

    // Next-state logic for configuration, history, fill and counter.
    always_comb begin
        pat_d     = pat_q;
        len_d     = len_q;
        overlap_d = overlap_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        cnt_d     = cnt_q;
        err_d     = 1'b0;
        match_q_d = match;

        if (cfg_we) begin
            if (cfg_len_ok) begin
                pat_d     = cfg_pattern;
                len_d     = cfg_len;
                overlap_d = cfg_overlap;
                hist_d    = '0;
                fill_d    = '0;
                cnt_d     = '0;
            end else begin
                err_d = 1'b1;
            end
        end else if (in_valid) begin
            // History always shifts; in non-overlap mode a match empties the
            // usable history so its bits cannot start the next match.
            hist_d = cand[WIDTH-2:0];
            if (fill_q != FILL_MAX) begin
                fill_d = fill_q + FILL_W'(1);
            end
            if (match && !overlap_q) begin
                fill_d = '0;
            end
            if (match && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pat_q     <= DEFAULT_PATTERN;
            len_q     <= LEN_W'(DEFAULT_LEN);
            overlap_q <= 1'b1;
            hist_q    <= '0;
            fill_q    <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            match_q   <= 1'b0;
        end else begin
            pat_q     <= pat_d;
            len_q     <= len_d;
            overlap_q <= overlap_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            match_q   <= match_q_d;
        end
    end

    assign match_cnt = cnt_q;
    assign cfg_err   = err_q;

endmodule

// File: tb/tb_seq_detect_prog.sv
// Bench for seq_detect_prog: two instances (CNT_W=8 and CNT_W=2) share all
// inputs. Every driver task occupies exactly one clock and pushes the
// expected Mealy match for that cycle; a negedge monitor pops and checks
// match, and checks match_q against the previous cycle's expectation.
module tb_seq_detect_prog;

  localparam int WIDTH = 8;
  localparam int LEN_W = $clog2(WIDTH + 1);

  logic             clk;
  logic             rst;
  logic             cfg_we;
  logic [WIDTH-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic             cfg_overlap;
  logic             in_valid;
  logic             in_bit;

  logic             cfg_err,  cfg_err2;
  logic             match,    match2;
  logic             match_q,  match_q2;
  logic [7:0]       match_cnt;
  logic [1:0]       match_cnt2;

  int total = 0;
  int bad   = 0;
  logic started = 1'b0;
  logic prev_e  = 1'b0;
  logic [0:0] exp_q[$];

  seq_detect_prog #(.WIDTH(WIDTH), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_err(cfg_err),
    .in_valid(in_valid), .in(in_bit), .match(match), .match_q(match_q),
    .match_cnt(match_cnt)
  );

  seq_detect_prog #(.WIDTH(WIDTH), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_err(cfg_err2),
    .in_valid(in_valid), .in(in_bit), .match(match2), .match_q(match_q2),
    .match_cnt(match_cnt2)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks: each consumes one cycle and pushes one expectation
  task automatic step(input logic v, input logic b, input logic exp_m);
    @(posedge clk); #1;
    rst = 1'b1; cfg_we = 1'b0; in_valid = v; in_bit = b;
    exp_q.push_back(exp_m);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic cfg(input logic [WIDTH-1:0] p, input logic [LEN_W-1:0] l,
                     input logic ov, input logic v, input logic b);
    @(posedge clk); #1;
    rst = 1'b1; cfg_we = 1'b1; cfg_pattern = p; cfg_len = l; cfg_overlap = ov;
    in_valid = v; in_bit = b;
    exp_q.push_back(1'b0);
  endtask

  task automatic do_reset(input logic v, input logic b);
    @(posedge clk); #1;
    rst = 1'b0; cfg_we = 1'b0; in_valid = v; in_bit = b;
    exp_q.push_back(1'b0);
  endtask

  task automatic stream(input logic [7:0] bits, input logic [7:0] exps, input int n);
    for (int i = n - 1; i >= 0; i--) step(1'b1, bits[i], exps[i]);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (started) begin
      logic e;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b0;
      chk("match", {31'd0, match}, {31'd0, e});
      chk("match_q", {31'd0, match_q}, {31'd0, prev_e});
      prev_e = e;
    end
  end

  initial begin
    rst = 1'b0; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0;
    cfg_overlap = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("reset_match", {31'd0, match}, 32'd0);
    chk("reset_match_q", {31'd0, match_q}, 32'd0);
    chk("reset_cnt", {24'd0, match_cnt}, 32'd0);
    chk("reset_err", {31'd0, cfg_err}, 32'd0);
    started = 1'b1;

    // defaults 1001 len 4 overlapping
    stream(8'b1100_1001, 8'b0000_1001, 8);
    idle();
    chk("dflt_cnt", {24'd0, match_cnt}, 32'd2);
    chk("dflt_cnt2", {30'd0, match_cnt2}, 32'd2);

    // non-overlapping
    cfg(8'b0000_1001, 4'd4, 1'b0, 1'b0, 1'b0);
    idle();
    chk("novl_err", {31'd0, cfg_err}, 32'd0);
    chk("novl_cnt_clr", {24'd0, match_cnt}, 32'd0);
    stream(8'b1100_1001, 8'b0000_1000, 8);
    idle();
    chk("novl_cnt", {24'd0, match_cnt}, 32'd1);

    // stall: 1,0,0, three idle with in toggling, then 1
    cfg(8'b0000_1001, 4'd4, 1'b1, 1'b0, 1'b0);
    stream(8'b0000_0100, 8'b0000_0000, 3);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    idle();
    chk("stall_cnt", {24'd0, match_cnt}, 32'd1);

    // max length 8, pattern A5
    cfg(8'hA5, 4'd8, 1'b1, 1'b0, 1'b0);
    stream(8'b1010_0101, 8'b0000_0001, 8);
    idle();
    chk("len8_cnt", {24'd0, match_cnt}, 32'd1);

    // len 1, pattern 1
    cfg(8'h01, 4'd1, 1'b1, 1'b0, 1'b0);
    stream(8'b0000_0101, 8'b0000_0101, 3);
    idle();
    chk("len1_cnt", {24'd0, match_cnt}, 32'd2);

    // rejected writes: len 0 and len 9
    cfg(8'hFF, 4'd0, 1'b0, 1'b0, 1'b0);
    idle();
    chk("err_len0_pulse", {31'd0, cfg_err}, 32'd1);
    idle();
    chk("err_len0_clear", {31'd0, cfg_err}, 32'd0);
    chk("err_cnt_hold", {24'd0, match_cnt}, 32'd2);
    cfg(8'h00, 4'd9, 1'b0, 1'b0, 1'b0);
    idle();
    chk("err_len9_pulse", {31'd0, cfg_err}, 32'd1);
    step(1'b1, 1'b1, 1'b1);   // old len-1 pattern still active
    idle();
    chk("err_len9_clear", {31'd0, cfg_err}, 32'd0);
    chk("err_old_pat_cnt", {24'd0, match_cnt}, 32'd3);
    chk("err_old_pat_cnt2", {30'd0, match_cnt2}, 32'd3);

    // cfg_we together with a completing bit: bit discarded, count cleared
    cfg(8'h01, 4'd1, 1'b1, 1'b1, 1'b1);
    idle();
    chk("prio_cnt", {24'd0, match_cnt}, 32'd0);
    chk("prio_err", {31'd0, cfg_err}, 32'd0);

    // saturation: five matches
    stream(8'b0001_1111, 8'b0001_1111, 5);
    idle();
    chk("sat_cnt8", {24'd0, match_cnt}, 32'd5);
    chk("sat_cnt2", {30'd0, match_cnt2}, 32'd3);

    // reset mid-pattern; upper pattern bits are ignored (F9 len 4 = 1001)
    cfg(8'hF9, 4'd4, 1'b1, 1'b0, 1'b0);
    stream(8'b0000_0100, 8'b0000_0000, 3);
    do_reset(1'b1, 1'b1);     // would complete 1001 if not in reset
    step(1'b1, 1'b1, 1'b0);
    idle();
    chk("rst_cnt", {24'd0, match_cnt}, 32'd0);
    chk("rst_cnt2", {30'd0, match_cnt2}, 32'd0);

    idle();
    idle();
    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
